// File: rtl/demux1to3_buf.sv
// Buffered 1-to-3 demultiplexer: a 2-entry FIFO of {sel, data} whose head word
// is steered to exactly one of three consumers; illegal selects are dropped and flagged.
module demux1to3_buf #(
    parameter int DWIDTH = 32
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic [DWIDTH-1:0] Demux_In,
    input  logic [1:0]        Output_Sel,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [DWIDTH-1:0] Demux_Out_A,
    output logic [DWIDTH-1:0] Demux_Out_B,
    output logic [DWIDTH-1:0] Demux_Out_C,
    output logic              Out_Valid_A,
    output logic              Out_Valid_B,
    output logic              Out_Valid_C,
    input  logic              Out_Ready_A,
    input  logic              Out_Ready_B,
    input  logic              Out_Ready_C,
    output logic              Sel_Err
);

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_C   = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    logic [DWIDTH-1:0] r_mem_data [2];
    logic [1:0]        r_mem_sel  [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              r_in_ready;
    logic              r_sel_err;
    logic              r_valid_a;
    logic              r_valid_b;
    logic              r_valid_c;
    logic [DWIDTH-1:0] r_data_a;
    logic [DWIDTH-1:0] r_data_b;
    logic [DWIDTH-1:0] r_data_c;

    logic              w_accept;
    logic              w_push;
    logic              w_bad;
    logic              w_pop;
    logic              w_wptr_nxt;
    logic              w_rptr_nxt;
    logic [1:0]        w_count_nxt;
    logic [1:0]        w_head_sel_nxt;
    logic [DWIDTH-1:0] w_head_data_nxt;
    logic              w_valid_a_nxt;
    logic              w_valid_b_nxt;
    logic              w_valid_c_nxt;
    logic [DWIDTH-1:0] w_data_a_nxt;
    logic [DWIDTH-1:0] w_data_b_nxt;
    logic [DWIDTH-1:0] w_data_c_nxt;

    // Handshake decode; the registered valids already encode which output holds the head.
    always_comb begin
        w_accept = In_Valid && r_in_ready;
        w_push   = w_accept && (Output_Sel != SEL_BAD);
        w_bad    = w_accept && (Output_Sel == SEL_BAD);
        w_pop    = (r_valid_a && Out_Ready_A) ||
                   (r_valid_b && Out_Ready_B) ||
                   (r_valid_c && Out_Ready_C);
    end

    // Pointer and occupancy update.
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        if (w_push) begin
            w_wptr_nxt = ~r_wptr;
        end else begin
            w_wptr_nxt = r_wptr;
        end
        if (w_pop) begin
            w_rptr_nxt = ~r_rptr;
        end else begin
            w_rptr_nxt = r_rptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Next head: the incoming word lands at the head slot when the FIFO is
    // empty, or when it holds one word that is popped this same cycle.
    always_comb begin
        w_head_sel_nxt  = r_mem_sel[w_rptr_nxt];
        w_head_data_nxt = r_mem_data[w_rptr_nxt];
        if (w_push && (r_wptr == w_rptr_nxt)) begin
            w_head_sel_nxt  = Output_Sel;
            w_head_data_nxt = Demux_In;
        end else begin
            w_head_sel_nxt  = r_mem_sel[w_rptr_nxt];
            w_head_data_nxt = r_mem_data[w_rptr_nxt];
        end
    end

    // Steer the next head to its single destination; the other lanes drive zero.
    always_comb begin
        w_valid_a_nxt = 1'b0;
        w_valid_b_nxt = 1'b0;
        w_valid_c_nxt = 1'b0;
        w_data_a_nxt  = {DWIDTH{1'b0}};
        w_data_b_nxt  = {DWIDTH{1'b0}};
        w_data_c_nxt  = {DWIDTH{1'b0}};
        if (w_count_nxt != 2'd0) begin
            case (w_head_sel_nxt)
                SEL_A: begin
                    w_valid_a_nxt = 1'b1;
                    w_data_a_nxt  = w_head_data_nxt;
                end
                SEL_B: begin
                    w_valid_b_nxt = 1'b1;
                    w_data_b_nxt  = w_head_data_nxt;
                end
                SEL_C: begin
                    w_valid_c_nxt = 1'b1;
                    w_data_c_nxt  = w_head_data_nxt;
                end
                default: begin
                    w_valid_a_nxt = 1'b0;
                    w_valid_b_nxt = 1'b0;
                    w_valid_c_nxt = 1'b0;
                end
            endcase
        end else begin
            w_valid_a_nxt = 1'b0;
            w_valid_b_nxt = 1'b0;
            w_valid_c_nxt = 1'b0;
        end
    end

    // FIFO storage write.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_mem_data[0] <= {DWIDTH{1'b0}};
            r_mem_data[1] <= {DWIDTH{1'b0}};
            r_mem_sel[0]  <= 2'b00;
            r_mem_sel[1]  <= 2'b00;
        end else if (w_push) begin
            r_mem_data[r_wptr] <= Demux_In;
            r_mem_sel[r_wptr]  <= Output_Sel;
        end
    end

    // Pointers, occupancy and the sticky illegal-select flag.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_sel_err <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_bad) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    // Output registers, loaded from next state so they mirror the FIFO head exactly.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_in_ready <= 1'b1;
            r_valid_a  <= 1'b0;
            r_valid_b  <= 1'b0;
            r_valid_c  <= 1'b0;
            r_data_a   <= {DWIDTH{1'b0}};
            r_data_b   <= {DWIDTH{1'b0}};
            r_data_c   <= {DWIDTH{1'b0}};
        end else begin
            r_in_ready <= (w_count_nxt != 2'd2);
            r_valid_a  <= w_valid_a_nxt;
            r_valid_b  <= w_valid_b_nxt;
            r_valid_c  <= w_valid_c_nxt;
            r_data_a   <= w_data_a_nxt;
            r_data_b   <= w_data_b_nxt;
            r_data_c   <= w_data_c_nxt;
        end
    end

    assign In_Ready    = r_in_ready;
    assign Sel_Err     = r_sel_err;
    assign Out_Valid_A = r_valid_a;
    assign Out_Valid_B = r_valid_b;
    assign Out_Valid_C = r_valid_c;
    assign Demux_Out_A = r_data_a;
    assign Demux_Out_B = r_data_b;
    assign Demux_Out_C = r_data_c;

endmodule

// File: tb/tb_demux1to3_buf.sv
// Self-checking bench for demux1to3_buf: directed scenarios plus random traffic
// compared against a queue-based model of the buffered demultiplexer.
module tb_demux1to3_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  in_sel = 2'b00;
    logic        in_valid = 1'b0;
    logic        rdy_a = 1'b0;
    logic        rdy_b = 1'b0;
    logic        rdy_c = 1'b0;
    logic        In_Ready, Sel_Err;
    logic        Out_Valid_A, Out_Valid_B, Out_Valid_C;
    logic [31:0] Demux_Out_A, Demux_Out_B, Demux_Out_C;

    int checks = 0;
    int errors = 0;

    // Model: queue of accepted {sel,data} words plus the sticky error flag.
    logic [33:0] q[$];
    bit          m_err = 1'b0;

    demux1to3_buf #(.DWIDTH(32)) dut (
        .Clk(clk), .Rst_N(rst_n),
        .Demux_In(in_data), .Output_Sel(in_sel),
        .In_Valid(in_valid), .In_Ready(In_Ready),
        .Demux_Out_A(Demux_Out_A), .Demux_Out_B(Demux_Out_B), .Demux_Out_C(Demux_Out_C),
        .Out_Valid_A(Out_Valid_A), .Out_Valid_B(Out_Valid_B), .Out_Valid_C(Out_Valid_C),
        .Out_Ready_A(rdy_a), .Out_Ready_B(rdy_b), .Out_Ready_C(rdy_c),
        .Sel_Err(Sel_Err)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] act(int k);
        case (k)
            0:       return {Out_Valid_A, Demux_Out_A};
            1:       return {Out_Valid_B, Demux_Out_B};
            default: return {Out_Valid_C, Demux_Out_C};
        endcase
    endfunction

    function automatic logic [32:0] exp_out(int k);
        if (q.size() > 0 && q[0][33:32] == 2'(k)) return {1'b1, q[0][31:0]};
        return 33'h0;
    endfunction

    // One clock edge; the model accepts/pops using the pre-edge inputs.
    task automatic tick();
        bit acc, pop;
        acc = in_valid && (q.size() < 2);
        pop = 1'b0;
        if (q.size() > 0) begin
            case (q[0][33:32])
                2'b00:   pop = rdy_a;
                2'b01:   pop = rdy_b;
                2'b10:   pop = rdy_c;
                default: pop = 1'b0;
            endcase
        end
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            if (in_sel == 2'b11) m_err = 1'b1;
            else q.push_back({in_sel, in_data});
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d);
        in_valid = v; in_sel = s; in_data = d;
    endtask

    task automatic test_power_on();
        #12 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act(k) !== 33'h0) begin
                errors++;
                $display("FAIL por_out%0d: got %h expected 0", k, act(k));
            end
        end
        checks++;
        if (In_Ready !== 1'b1 || Sel_Err !== 1'b0) begin
            errors++;
            $display("FAIL por_ctrl: In_Ready=%b Sel_Err=%b expected 1/0", In_Ready, Sel_Err);
        end
    endtask

    task automatic test_routing();
        logic [31:0] words [3];
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i), words[i]);
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act(k) !== ((k == i) ? {1'b1, words[i]} : 33'h0)) begin
                    errors++;
                    $display("FAIL route w%0d out%0d: got %h expected %h", i, k, act(k),
                             (k == i) ? {1'b1, words[i]} : 33'h0);
                end
            end
        end
        drive(1'b0, 2'b00, 32'h0);
        tick();
        checks++;
        if ({Out_Valid_A, Out_Valid_B, Out_Valid_C} !== 3'b000) begin
            errors++;
            $display("FAIL route_drain: valids %b expected 000", {Out_Valid_A, Out_Valid_B, Out_Valid_C});
        end
    endtask

    task automatic test_back_to_back_full();
        rdy_a = 1'b1; rdy_b = 1'b0; rdy_c = 1'b1;
        drive(1'b1, 2'b01, 32'hAAAA0001);
        tick();
        checks++;
        if (In_Ready !== 1'b1 || act(1) !== {1'b1, 32'hAAAA0001}) begin
            errors++;
            $display("FAIL bp_first: In_Ready=%b B=%h expected 1/1aaaa0001", In_Ready, act(1));
        end
        drive(1'b1, 2'b00, 32'hAAAA0002);
        tick();
        drive(1'b1, 2'b10, 32'hAAAA0003);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (In_Ready !== 1'b0 || Out_Valid_A !== 1'b0 || act(1) !== {1'b1, 32'hAAAA0001}) begin
                errors++;
                $display("FAIL bp_full%0d: In_Ready=%b ValidA=%b B=%h expected 0/0/1aaaa0001",
                         i, In_Ready, Out_Valid_A, act(1));
            end
            tick();
        end
        // Stalled three edges; third word is still held by the producer.
        rdy_b = 1'b1;
        tick();
        checks++;
        if (In_Ready !== 1'b1 || act(0) !== {1'b1, 32'hAAAA0002} || Out_Valid_B !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: In_Ready=%b A=%h ValidB=%b expected 1/1aaaa0002/0",
                     In_Ready, act(0), Out_Valid_B);
        end
        tick();
        drive(1'b0, 2'b00, 32'h0);
        checks++;
        if (act(2) !== {1'b1, 32'hAAAA0003} || Out_Valid_A !== 1'b0) begin
            errors++;
            $display("FAIL bp_third: C=%h ValidA=%b expected 1aaaa0003/0", act(2), Out_Valid_A);
        end
        tick();
    endtask

    task automatic test_push_pop();
        rdy_c = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'b10, 32'(i));
            tick();
            checks++;
            if (act(2) !== {1'b1, 32'(i)} || In_Ready !== 1'b1 || q.size() != 1) begin
                errors++;
                $display("FAIL pushpop%0d: C=%h In_Ready=%b expected %h/1", i, act(2), In_Ready,
                         {1'b1, 32'(i)});
            end
        end
        drive(1'b0, 2'b00, 32'h0);
        tick();
        checks++;
        if (Out_Valid_C !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_end: ValidC=%b expected 0", Out_Valid_C);
        end
    endtask

    task automatic test_stability();
        rdy_a = 1'b0;
        drive(1'b1, 2'b00, 32'h12345678);
        tick();
        drive(1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (act(0) !== {1'b1, 32'h12345678}) begin
                errors++;
                $display("FAIL stable%0d: A=%h expected 112345678", i, act(0));
            end
            tick();
        end
        rdy_a = 1'b1;
        tick();
        checks++;
        if (Out_Valid_A !== 1'b0) begin
            errors++;
            $display("FAIL stable_pop: ValidA=%b expected 0", Out_Valid_A);
        end
    endtask

    task automatic test_illegal_sel();
        rdy_a = 1'b0;
        drive(1'b1, 2'b00, 32'h0000CAFE);
        tick();
        drive(1'b1, 2'b11, 32'hDEADBEEF);
        tick();
        drive(1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (Sel_Err !== 1'b1 || In_Ready !== 1'b1 || act(0) !== {1'b1, 32'h0000CAFE} ||
                Out_Valid_B !== 1'b0 || Out_Valid_C !== 1'b0) begin
                errors++;
                $display("FAIL illegal%0d: Sel_Err=%b In_Ready=%b A=%h expected 1/1/10000cafe",
                         i, Sel_Err, In_Ready, act(0));
            end
            tick();
        end
        rdy_a = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        drive(1'b1, 2'b01, 32'h0BAD0001);
        tick();
        drive(1'b1, 2'b10, 32'h0BAD0002);
        tick();
        drive(1'b0, 2'b00, 32'h0);
        checks++;
        if (In_Ready !== 1'b0 || Sel_Err !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: In_Ready=%b Sel_Err=%b expected 0/1", In_Ready, Sel_Err);
        end
        #3 rst_n = 1'b0;
        q.delete();
        m_err = 1'b0;
        #1;
        checks++;
        if (In_Ready !== 1'b1 || Sel_Err !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctrl: In_Ready=%b Sel_Err=%b expected 1/0", In_Ready, Sel_Err);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act(k) !== 33'h0) begin
                errors++;
                $display("FAIL rst_out%0d: got %h expected 0", k, act(k));
            end
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                  $urandom);
            rdy_a = ($urandom_range(0, 2) != 0);
            rdy_b = ($urandom_range(0, 2) != 0);
            rdy_c = ($urandom_range(0, 2) != 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act(k) !== exp_out(k)) begin
                    errors++;
                    $display("FAIL rand c%0d out%0d: got %h expected %h", c, k, act(k), exp_out(k));
                end
            end
            checks++;
            if (In_Ready !== (q.size() < 2) || Sel_Err !== m_err) begin
                errors++;
                $display("FAIL rand c%0d ctrl: In_Ready=%b Sel_Err=%b expected %b/%b",
                         c, In_Ready, Sel_Err, (q.size() < 2), m_err);
            end
        end
        drive(1'b0, 2'b00, 32'h0);
    endtask

    initial begin
        test_power_on();
        test_routing();
        test_back_to_back_full();
        test_push_pop();
        test_stability();
        test_illegal_sel();
        test_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
